// File: rtl/twobit_pkg.sv
// Shared definitions for the ID-stage branch resolver and its 2-bit BHT/BTB.
// Contents:
//   BR_XLEN / BR_ENTRIES  default data/PC width and table depth; the table entry
//                         layout below is sized from these, so module parameters
//                         must keep these values
//   OP_BRANCH, F3_*       op class and funct3 encodings for conditional branches
//   bht_entry_t           one table entry {valid, tag, target, ctr}
//   sat2()                saturating 2-bit counter step
package twobit_pkg;

    localparam int unsigned BR_XLEN    = 32;
    localparam int unsigned BR_ENTRIES = 16;
    localparam int unsigned BR_IDX     = $clog2(BR_ENTRIES);
    localparam int unsigned BR_TAG_W   = BR_XLEN - BR_IDX - 2;

    localparam logic [2:0] OP_BRANCH = 3'b110;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weakly not-taken after reset, weakly taken on allocation.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [BR_TAG_W-1:0] tag;
        logic [BR_XLEN-1:0]  target;
        logic [1:0]          ctr;
    } bht_entry_t;

    // One step of a 2-bit saturating counter: up=1 counts toward 11, up=0 toward 00.
    function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != 2'b11) begin
                res = ctr + 2'b01;
            end else begin
                res = ctr;
            end
        end else begin
            if (ctr != 2'b00) begin
                res = ctr - 2'b01;
            end else begin
                res = ctr;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_2bit_table.sv
// Tagged branch history / target table with 2-bit saturating counters.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears all entries)
//   lkp_pc_i         word-aligned fetch PC (bits XLEN-1:2) for the IF lookup
//   lkp_taken_o      lookup hit and counter MSB set
//   lkp_target_o     stored target on a hit, zero otherwise
//   upd_en_i         a branch resolves this cycle
//   upd_pc_i         word-aligned PC (bits XLEN-1:2) of the resolving branch
//   upd_taken_i      resolved direction
//   upd_target_i     resolved target
// The lookup reads the registered array only, so a lookup and an update at the
// same index in the same cycle see the entry as it was before the update.
module bht_2bit_table
    import twobit_pkg::*;
#(
    parameter int unsigned XLEN    = BR_XLEN,
    parameter int unsigned ENTRIES = BR_ENTRIES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:2] lkp_pc_i,
    output logic            lkp_taken_o,
    output logic [XLEN-1:0] lkp_target_o,
    input  logic            upd_en_i,
    input  logic [XLEN-1:2] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    bht_entry_t tbl_q [ENTRIES];

    logic [IDX-1:0]   lkp_idx_s;
    logic [TAG_W-1:0] lkp_tag_s;
    logic [IDX-1:0]   upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    bht_entry_t       upd_old_s;
    bht_entry_t       upd_new_s;
    logic             upd_hit_s;
    logic             upd_we_s;

    assign lkp_idx_s = lkp_pc_i[IDX+1:2];
    assign lkp_tag_s = lkp_pc_i[XLEN-1:IDX+2];
    assign upd_idx_s = upd_pc_i[IDX+1:2];
    assign upd_tag_s = upd_pc_i[XLEN-1:IDX+2];

    // IF lookup: hit requires a valid entry with a matching tag.
    always_comb begin
        lkp_taken_o  = 1'b0;
        lkp_target_o = {XLEN{1'b0}};
        if (tbl_q[lkp_idx_s].valid && (tbl_q[lkp_idx_s].tag == lkp_tag_s)) begin
            lkp_taken_o  = tbl_q[lkp_idx_s].ctr[1];
            lkp_target_o = tbl_q[lkp_idx_s].target;
        end else begin
            lkp_taken_o  = 1'b0;
            lkp_target_o = {XLEN{1'b0}};
        end
    end

    // Update entry: train on a hit, allocate only on a taken miss.
    always_comb begin
        upd_old_s = tbl_q[upd_idx_s];
        upd_hit_s = upd_old_s.valid && (upd_old_s.tag == upd_tag_s);
        upd_new_s = upd_old_s;
        upd_we_s  = 1'b0;
        if (upd_en_i) begin
            if (upd_hit_s) begin
                upd_we_s      = 1'b1;
                upd_new_s.ctr = sat2(upd_old_s.ctr, upd_taken_i);
                if (upd_taken_i) begin
                    upd_new_s.target = upd_target_i;
                end else begin
                    upd_new_s.target = upd_old_s.target;
                end
            end else if (upd_taken_i) begin
                upd_we_s         = 1'b1;
                upd_new_s.valid  = 1'b1;
                upd_new_s.tag    = upd_tag_s;
                upd_new_s.target = upd_target_i;
                upd_new_s.ctr    = CTR_ALLOC;
            end else begin
                upd_we_s = 1'b0;
            end
        end else begin
            upd_we_s = 1'b0;
        end
    end

    // Table storage; reset wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= {TAG_W{1'b0}};
                tbl_q[i].target <= {XLEN{1'b0}};
                tbl_q[i].ctr    <= CTR_RESET;
            end
        end else if (upd_we_s) begin
            tbl_q[upd_idx_s] <= upd_new_s;
        end
    end

endmodule

// File: rtl/id_branch_resolve.sv
// ID-stage branch resolution and 2-bit prediction unit.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_pc / pred_taken /      IF lookup into the BHT/BTB (combinational)
//   pred_target
//   id_valid, id_op,          ID instruction: op class, branch kind, PC, B-immediate
//   id_funct3, id_pc, id_imm
//   id_pred_taken,            prediction that travelled with the instruction from IF
//   id_pred_target
//   rs1_id, rs2_id,           source indices and register-file data
//   rs1_data, rs2_data
//   mem_fwd_data, th1,        forwarding unit: MEM result, EX-hazard stall,
//   th2_1, th2_2              MEM-forward selects for rs1/rs2
//   id_advance                ID instruction moves to EX this cycle
//   stall_id                  hold PC and IF/ID
//   flush_ifid, redirect_pc   one-cycle squash plus corrected fetch PC on a mispredict
//   br_cnt, mispred_cnt       resolved-branch and mispredict counters (wrapping)
// All outputs read as zero while rst is high.
module id_branch_resolve
    import twobit_pkg::*;
#(
    parameter int unsigned ENTRIES = BR_ENTRIES,
    parameter int unsigned XLEN    = BR_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            id_valid,
    input  logic [2:0]      id_op,
    input  logic [2:0]      id_funct3,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_pred_taken,
    input  logic [XLEN-1:0] id_pred_target,
    input  logic [4:0]      rs1_id,
    input  logic [4:0]      rs2_id,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            th1,
    input  logic            th2_1,
    input  logic            th2_2,
    input  logic            id_advance,
    output logic            stall_id,
    output logic            flush_ifid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic            is_br_s;
    logic            fwd_b_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic            taken_s;
    logic [XLEN-1:0] target_s;
    logic            resolve_s;
    logic            mispredict_s;
    logic            lkp_taken_s;
    logic [XLEN-1:0] lkp_target_s;

    logic            resolved_q;
    logic            resolved_d;
    logic [31:0]     br_cnt_q;
    logic [31:0]     br_cnt_d;
    logic [31:0]     mis_cnt_q;
    logic [31:0]     mis_cnt_d;

    assign is_br_s = id_valid && (id_op == OP_BRANCH);

    // rs2 also takes the MEM value when it names the same non-zero register
    // that the forwarding unit already flagged for rs1.
    assign fwd_b_s  = th2_2 || (th2_1 && (rs1_id == rs2_id) && (rs2_id != 5'd0));
    assign op_a_s   = th2_1   ? mem_fwd_data : rs1_data;
    assign op_b_s   = fwd_b_s ? mem_fwd_data : rs2_data;
    assign target_s = id_pc + id_imm;

    // Branch condition; reserved funct3 encodings resolve not taken.
    always_comb begin
        taken_s = 1'b0;
        case (id_funct3)
            F3_BEQ:  taken_s = (op_a_s == op_b_s);
            F3_BNE:  taken_s = (op_a_s != op_b_s);
            F3_BLT:  taken_s = ($signed(op_a_s) <  $signed(op_b_s));
            F3_BGE:  taken_s = ($signed(op_a_s) >= $signed(op_b_s));
            F3_BLTU: taken_s = (op_a_s <  op_b_s);
            F3_BGEU: taken_s = (op_a_s >= op_b_s);
            default: taken_s = 1'b0;
        endcase
    end

    // resolved_q blocks a second resolve while the same instruction sits in ID.
    assign resolve_s    = is_br_s && !th1 && !resolved_q;
    assign mispredict_s = resolve_s &&
                          ((taken_s != id_pred_taken) ||
                           (taken_s && (id_pred_target != target_s)));

    bht_2bit_table #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .lkp_pc_i     (if_pc[XLEN-1:2]),
        .lkp_taken_o  (lkp_taken_s),
        .lkp_target_o (lkp_target_s),
        .upd_en_i     (resolve_s),
        .upd_pc_i     (id_pc[XLEN-1:2]),
        .upd_taken_i  (taken_s),
        .upd_target_i (target_s)
    );

    // Next state for the resolved flag and the event counters.
    always_comb begin
        resolved_d = resolved_q;
        br_cnt_d   = br_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        if (id_advance || mispredict_s) begin
            resolved_d = 1'b0;
        end else if (resolve_s) begin
            resolved_d = 1'b1;
        end else begin
            resolved_d = resolved_q;
        end
        if (resolve_s) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (mispredict_s) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end else begin
            mis_cnt_d = mis_cnt_q;
        end
    end

    // State registers; reset discards any update pending this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_q <= 1'b0;
            br_cnt_q   <= 32'd0;
            mis_cnt_q  <= 32'd0;
        end else begin
            resolved_q <= resolved_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // Output drive, forced to zero during reset.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = {XLEN{1'b0}};
        stall_id    = 1'b0;
        flush_ifid  = 1'b0;
        redirect_pc = {XLEN{1'b0}};
        br_cnt      = 32'd0;
        mispred_cnt = 32'd0;
        if (rst) begin
            pred_taken  = 1'b0;
            pred_target = {XLEN{1'b0}};
        end else begin
            pred_taken  = lkp_taken_s;
            pred_target = lkp_target_s;
            stall_id    = is_br_s && th1;
            flush_ifid  = mispredict_s;
            if (mispredict_s) begin
                redirect_pc = taken_s ? target_s : (id_pc + PC_STEP);
            end else begin
                redirect_pc = {XLEN{1'b0}};
            end
            br_cnt      = br_cnt_q;
            mispred_cnt = mis_cnt_q;
        end
    end

endmodule

// File: tb/tb_id_branch_resolve.sv
module tb_id_branch_resolve;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid;
    logic [2:0]  id_op;
    logic [2:0]  id_funct3;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] mem_fwd_data;
    logic        th1;
    logic        th2_1;
    logic        th2_2;
    logic        id_advance;
    logic        stall_id;
    logic        flush_ifid;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int tests_run;
    int tests_failed;

    id_branch_resolve #(.ENTRIES(16), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .id_valid(id_valid), .id_op(id_op), .id_funct3(id_funct3), .id_pc(id_pc), .id_imm(id_imm),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mem_fwd_data(mem_fwd_data), .th1(th1), .th2_1(th2_1), .th2_2(th2_2),
        .id_advance(id_advance), .stall_id(stall_id), .flush_ifid(flush_ifid),
        .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_ctr   [16];
    logic [31:0] m_br, m_mis;
    logic        m_resolved;

    logic        e_stall, e_flush, e_pt, e_resolve, e_taken;
    logic [31:0] e_redirect, e_ptgt, e_br, e_mis, e_target;

    function automatic logic cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 26'd0; m_tgt[i] = 32'd0; m_ctr[i] = 2'd1;
        end
        m_br = 32'd0; m_mis = 32'd0; m_resolved = 1'b0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int idx;
        idx = int'(pc[5:2]);
        if (m_valid[idx] && m_tag[idx] == pc[31:6]) begin
            t = m_ctr[idx] >= 2'd2; tg = m_tgt[idx];
        end else begin
            t = 1'b0; tg = 32'd0;
        end
    endtask

    task automatic model_eval();
        logic        is_br;
        logic [31:0] a, b;
        is_br      = id_valid && id_op == 3'b110;
        a          = th2_1 ? mem_fwd_data : rs1_data;
        b          = (th2_2 || (th2_1 && rs1_id == rs2_id && rs2_id != 5'd0)) ? mem_fwd_data : rs2_data;
        e_taken    = cond(id_funct3, a, b);
        e_target   = id_pc + id_imm;
        e_resolve  = !rst && is_br && !th1 && !m_resolved;
        e_flush    = e_resolve && (e_taken != id_pred_taken || (e_taken && id_pred_target != e_target));
        e_stall    = !rst && is_br && th1;
        e_redirect = e_taken ? e_target : id_pc + 32'd4;
        model_lookup(if_pc, e_pt, e_ptgt);
        if (rst) begin e_pt = 1'b0; e_ptgt = 32'd0; end
        e_br  = rst ? 32'd0 : m_br;
        e_mis = rst ? 32'd0 : m_mis;
    endtask

    task automatic model_commit();
        int idx;
        if (rst) begin
            model_reset();
        end else begin
            if (e_resolve) begin
                idx = int'(id_pc[5:2]);
                if (m_valid[idx] && m_tag[idx] == id_pc[31:6]) begin
                    if (e_taken) begin
                        m_ctr[idx] = (m_ctr[idx] == 2'd3) ? 2'd3 : m_ctr[idx] + 2'd1;
                        m_tgt[idx] = e_target;
                    end else begin
                        m_ctr[idx] = (m_ctr[idx] == 2'd0) ? 2'd0 : m_ctr[idx] - 2'd1;
                    end
                end else if (e_taken) begin
                    m_valid[idx] = 1'b1; m_tag[idx] = id_pc[31:6];
                    m_tgt[idx] = e_target; m_ctr[idx] = 2'd2;
                end
                m_br = m_br + 32'd1;
            end
            if (e_flush) m_mis = m_mis + 32'd1;
            if (id_advance || e_flush) m_resolved = 1'b0;
            else if (e_resolve) m_resolved = 1'b1;
        end
    endtask

    // inputs are applied #1 after posedge; settle samples at negedge
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        if_pc = 32'd0; id_valid = 1'b0; id_op = 3'd0; id_funct3 = 3'd0; id_pc = 32'd0;
        id_imm = 32'd0; id_pred_taken = 1'b0; id_pred_target = 32'd0; rs1_id = 5'd0;
        rs2_id = 5'd0; rs1_data = 32'd0; rs2_data = 32'd0; mem_fwd_data = 32'd0;
        th1 = 1'b0; th2_1 = 1'b0; th2_2 = 1'b0; id_advance = 1'b0;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] d1, input logic [31:0] d2, input logic pt,
                              input logic [31:0] ptg);
        id_valid = 1'b1; id_op = 3'b110; id_funct3 = f3; id_pc = pc; id_imm = imm;
        rs1_data = d1; rs2_data = d2; rs1_id = 5'd1; rs2_id = 5'd2;
        id_pred_taken = pt; id_pred_target = ptg; id_advance = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        id_valid = 1'b1; id_op = 3'b110; th1 = 1'b1; if_pc = 32'h100;
        settle(); advance(); settle();
        tests_run++; if (stall_id !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b want 0", stall_id); end
        tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_pred: got %0b want 0", pred_taken); end
        advance();
        rst = 1'b0; idle_inputs(); if_pc = 32'h100;
        settle();
        tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_lookup: got %0b want 0", pred_taken); end
        tests_run++; if (br_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_br_cnt: got %0d want 0", br_cnt); end
        tests_run++; if (mispred_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_mis_cnt: got %0d want 0", mispred_cnt); end
        advance();
    endtask

    task automatic test_alloc();
        set_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0);
        settle();
        tests_run++; if (flush_ifid !== 1'b1) begin tests_failed++; $display("FAIL alloc_flush: got %0b want 1", flush_ifid); end
        tests_run++; if (redirect_pc !== 32'h120) begin tests_failed++; $display("FAIL alloc_redirect: got %h want 00000120", redirect_pc); end
        advance();
        idle_inputs(); if_pc = 32'h100;
        settle();
        tests_run++; if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL alloc_pred: got %0b want 1", pred_taken); end
        tests_run++; if (pred_target !== 32'h120) begin tests_failed++; $display("FAIL alloc_target: got %h want 00000120", pred_target); end
        advance();
    endtask

    task automatic test_saturate();
        // ctr 10 -> 01 (mispredicted against a taken prediction)
        set_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd6, 1'b1, 32'h120); if_pc = 32'h100;
        settle();
        tests_run++; if (flush_ifid !== 1'b1 || redirect_pc !== 32'h104) begin tests_failed++;
            $display("FAIL sat_nt_redirect: got flush=%0b pc=%h want 1/00000104", flush_ifid, redirect_pc); end
        advance(); id_valid = 1'b0;
        settle();
        tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL sat_ctr01: got %0b want 0", pred_taken); end
        advance();
        // two more not-taken: 01 -> 00 -> 00
        for (int k = 0; k < 2; k++) begin
            set_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd6, 1'b0, 32'd0); if_pc = 32'h100;
            settle();
            tests_run++; if (flush_ifid !== 1'b0) begin tests_failed++; $display("FAIL sat_nt_flush%0d: got %0b want 0", k, flush_ifid); end
            advance();
        end
        // one taken from saturated 00 -> 01, still predicts not taken
        set_branch(3'b000, 32'h100, 32'h20, 32'd6, 32'd6, 1'b0, 32'd0); if_pc = 32'h100;
        settle(); advance(); id_valid = 1'b0;
        settle();
        tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL sat_floor: got %0b want 0", pred_taken); end
        tests_run++; if (br_cnt !== 32'd5) begin tests_failed++; $display("FAIL sat_br_cnt: got %0d want 5", br_cnt); end
        tests_run++; if (mispred_cnt !== 32'd3) begin tests_failed++; $display("FAIL sat_mis_cnt: got %0d want 3", mispred_cnt); end
        advance();
    endtask

    task automatic test_stall();
        set_branch(3'b001, 32'h200, 32'h10, 32'd7, 32'd3, 1'b0, 32'd0);
        mem_fwd_data = 32'd7; th1 = 1'b1; id_advance = 1'b0; if_pc = 32'h200;
        for (int k = 0; k < 2; k++) begin
            settle();
            tests_run++; if (stall_id !== 1'b1) begin tests_failed++; $display("FAIL stall_cycle%0d: got %0b want 1", k, stall_id); end
            advance();
        end
        th1 = 1'b0; th2_2 = 1'b1;
        settle();
        tests_run++; if (stall_id !== 1'b0 || flush_ifid !== 1'b0) begin tests_failed++;
            $display("FAIL stall_release: got stall=%0b flush=%0b want 0/0", stall_id, flush_ifid); end
        advance();
        settle();
        tests_run++; if (br_cnt !== 32'd6) begin tests_failed++; $display("FAIL stall_br_once: got %0d want 6", br_cnt); end
        advance();
        id_advance = 1'b1;
        settle(); advance();
        idle_inputs(); if_pc = 32'h200;
        settle();
        tests_run++; if (br_cnt !== 32'd6) begin tests_failed++; $display("FAIL stall_br_held: got %0d want 6", br_cnt); end
        tests_run++; if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL stall_no_alloc: got %0b want 0", pred_taken); end
        advance();
    endtask

    task automatic test_signed_unsigned();
        set_branch(3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        settle();
        tests_run++; if (flush_ifid !== 1'b0) begin tests_failed++; $display("FAIL bltu_nt: got flush %0b want 0", flush_ifid); end
        advance();
        set_branch(3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        settle();
        tests_run++; if (flush_ifid !== 1'b1 || redirect_pc !== 32'h340) begin tests_failed++;
            $display("FAIL blt_taken: got flush=%0b pc=%h want 1/00000340", flush_ifid, redirect_pc); end
        advance();
    endtask

    task automatic test_fwd_and_reset();
        set_branch(3'b000, 32'h400, 32'h10, 32'd1, 32'd2, 1'b0, 32'd0);
        th2_1 = 1'b1; rs1_id = 5'd3; rs2_id = 5'd3; mem_fwd_data = 32'd9;
        settle();
        tests_run++; if (flush_ifid !== 1'b1 || redirect_pc !== 32'h410) begin tests_failed++;
            $display("FAIL fwd_both: got flush=%0b pc=%h want 1/00000410", flush_ifid, redirect_pc); end
        advance();
        // stall, then reset in the middle of it
        set_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'd0);
        th1 = 1'b1; id_advance = 1'b0; if_pc = 32'h400;
        settle();
        tests_run++; if (stall_id !== 1'b1 || pred_taken !== 1'b1) begin tests_failed++;
            $display("FAIL prerst: got stall=%0b pred=%0b want 1/1", stall_id, pred_taken); end
        advance();
        rst = 1'b1; th1 = 1'b0;
        settle();
        tests_run++; if (stall_id !== 1'b0 || flush_ifid !== 1'b0 || pred_taken !== 1'b0) begin tests_failed++;
            $display("FAIL rst_outputs: got stall=%0b flush=%0b pred=%0b want 0/0/0", stall_id, flush_ifid, pred_taken); end
        advance();
        rst = 1'b0; idle_inputs(); if_pc = 32'h400;
        settle();
        tests_run++; if (pred_taken !== 1'b0 || pred_target !== 32'd0) begin tests_failed++;
            $display("FAIL rst_table: got pred=%0b tgt=%h want 0/00000000", pred_taken, pred_target); end
        tests_run++; if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin tests_failed++;
            $display("FAIL rst_counters: got br=%0d mis=%0d want 0/0", br_cnt, mispred_cnt); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] pool [5];
        logic [31:0] imms [4];
        logic        mt;
        logic [31:0] mtg;
        pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'd5; pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h8000_0000;
        imms[0] = 32'h10; imms[1] = 32'hFFFF_FFE0; imms[2] = 32'h40; imms[3] = 32'h100;
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            if_pc        = 32'h1000 + 32'($urandom_range(0, 1)) * 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
            id_pc        = 32'h1000 + 32'($urandom_range(0, 1)) * 32'h400 + 32'($urandom_range(0, 7)) * 32'd4;
            id_valid     = ($urandom_range(0, 9) < 8);
            id_op        = ($urandom_range(0, 9) < 8) ? 3'b110 : 3'($urandom_range(0, 5));
            id_funct3    = 3'($urandom_range(0, 7));
            id_imm       = imms[$urandom_range(0, 3)];
            rs1_id       = 5'($urandom_range(0, 3));
            rs2_id       = 5'($urandom_range(0, 3));
            rs1_data     = pool[$urandom_range(0, 4)];
            rs2_data     = pool[$urandom_range(0, 4)];
            mem_fwd_data = pool[$urandom_range(0, 4)];
            th1          = ($urandom_range(0, 9) < 3);
            th2_1        = ($urandom_range(0, 3) == 0);
            th2_2        = ($urandom_range(0, 3) == 0);
            id_advance   = ($urandom_range(0, 1) == 1);
            model_lookup(id_pc, mt, mtg);
            if ($urandom_range(0, 1) == 1) begin
                id_pred_taken = mt; id_pred_target = mt ? mtg : 32'd0;
            end else begin
                id_pred_taken = 1'($urandom_range(0, 1)); id_pred_target = id_pc + imms[$urandom_range(0, 3)];
            end
            settle();
            tests_run++; if (stall_id !== e_stall) begin tests_failed++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, stall_id, e_stall); end
            tests_run++; if (flush_ifid !== e_flush) begin tests_failed++; $display("FAIL rnd_flush[%0d]: got %0b want %0b", n, flush_ifid, e_flush); end
            if (e_flush) begin
                tests_run++; if (redirect_pc !== e_redirect) begin tests_failed++; $display("FAIL rnd_redirect[%0d]: got %h want %h", n, redirect_pc, e_redirect); end
            end
            tests_run++; if (pred_taken !== e_pt || pred_target !== e_ptgt) begin tests_failed++;
                $display("FAIL rnd_pred[%0d]: got %0b/%h want %0b/%h", n, pred_taken, pred_target, e_pt, e_ptgt); end
            tests_run++; if (br_cnt !== e_br || mispred_cnt !== e_mis) begin tests_failed++;
                $display("FAIL rnd_counters[%0d]: got %0d/%0d want %0d/%0d", n, br_cnt, mispred_cnt, e_br, e_mis); end
            advance();
        end
        rst = 1'b0; idle_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_alloc();
        test_saturate();
        test_stall();
        test_signed_unsigned();
        test_fwd_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
